// File: rtl/serial_to_parallel.sv
// rtl/serial_to_parallel.sv - byte stream to N-bit word assembler, MSB-first
module serial_to_parallel #(
   parameter int N         = 32,
   parameter int Ndiv4log2 = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rx_valid,
   input  logic [7:0]   rx_byte,
   output logic [N-1:0] tx_bytes,
   output logic         tx_valid
);

   // Index of the last byte of a word; reaching it closes the word.
   localparam logic [Ndiv4log2-1:0] LAST_IDX = Ndiv4log2'(N / 8 - 1);

   logic [N-1:0]         shift_q, shift_d;
   logic [Ndiv4log2-1:0] count_q, count_d;
   logic                 valid_q, valid_d;

   // Shift accepted bytes in at the LSB end and flag the cycle after a word completes.
   always_comb begin
      shift_d = shift_q;
      count_d = count_q;
      valid_d = 1'b0;
      if (rx_valid) begin
         shift_d = {shift_q[N-9:0], rx_byte};
         if (count_q == LAST_IDX) begin
            count_d = '0;
            valid_d = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   // State registers; reset wins over a byte arriving on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   assign tx_bytes = shift_q;
   assign tx_valid = valid_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// tb/tb_serial_to_parallel.sv - directed self-checking bench for serial_to_parallel
module tb_serial_to_parallel;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic [31:0] tx_bytes32;
   logic [15:0] tx_bytes16;
   logic [63:0] tx_bytes64;
   logic        tx_valid32, tx_valid16, tx_valid64;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   serial_to_parallel #(.N(32), .Ndiv4log2(3)) u_dut32 (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .tx_bytes(tx_bytes32), .tx_valid(tx_valid32)
   );

   serial_to_parallel #(.N(16), .Ndiv4log2(2)) u_dut16 (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .tx_bytes(tx_bytes16), .tx_valid(tx_valid16)
   );

   serial_to_parallel #(.N(64), .Ndiv4log2(4)) u_dut64 (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .tx_bytes(tx_bytes64), .tx_valid(tx_valid64)
   );

   // Single comparison point: counts every check and reports any mismatch.
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present one input cycle, then sample just after the edge that consumes it.
   task automatic send(input logic v, input logic [7:0] b);
      rx_valid = v;
      rx_byte  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_chk(input logic v, input logic [7:0] b, input logic exp_v, input string tag);
      send(v, b);
      chk(tag, 64'(tx_valid32), 64'(exp_v));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      send(1'b0, 8'h00);
      rst = 1'b0;
   endtask

   logic [7:0] seq_b [0:7];
   logic       seq_v [0:7];

   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      send(1'b0, 8'h00);
      send(1'b0, 8'h00);
      chk("rst_bytes32", 64'(tx_bytes32), 64'h0);
      chk("rst_valid32", 64'(tx_valid32), 64'h0);
      chk("rst_bytes16", 64'(tx_bytes16), 64'h0);
      chk("rst_bytes64", tx_bytes64, 64'h0);
      rst = 1'b0;

      // Four consecutive bytes form one word.
      send_chk(1'b1, 8'hAA, 1'b0, "b2b_v1");
      send_chk(1'b1, 8'hBB, 1'b0, "b2b_v2");
      send_chk(1'b1, 8'hCC, 1'b0, "b2b_v3");
      send_chk(1'b1, 8'hDD, 1'b1, "b2b_v4");
      chk("b2b_word", 64'(tx_bytes32), 64'hAABBCCDD);
      send_chk(1'b0, 8'h00, 1'b0, "b2b_after");

      // Same bytes with idle gaps; valid must stay low until after DD.
      seq_b = '{8'hAA, 8'h00, 8'h00, 8'hBB, 8'h00, 8'hCC, 8'h00, 8'hDD};
      seq_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++)
         send_chk(seq_v[i], seq_b[i], (i == 7), $sformatf("gap_v%0d", i));
      chk("gap_word", 64'(tx_bytes32), 64'hAABBCCDD);
      send_chk(1'b0, 8'h00, 1'b0, "gap_after");

      // Two words streamed with no gap.
      seq_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      for (int i = 0; i < 8; i++) begin
         send_chk(1'b1, seq_b[i], (i == 3 || i == 7), $sformatf("stream_v%0d", i));
         if (i == 3) chk("stream_w1", 64'(tx_bytes32), 64'h11223344);
         if (i == 7) chk("stream_w2", 64'(tx_bytes32), 64'h55667788);
      end
      send_chk(1'b0, 8'h00, 1'b0, "stream_after");

      // Reset mid-word discards the partial word.
      send_chk(1'b1, 8'hAA, 1'b0, "mid_a");
      send_chk(1'b1, 8'hBB, 1'b0, "mid_b");
      rst = 1'b1;
      send_chk(1'b0, 8'h00, 1'b0, "mid_rst");
      rst = 1'b0;
      send_chk(1'b0, 8'h00, 1'b0, "mid_post");
      send_chk(1'b1, 8'h01, 1'b0, "mid_v1");
      send_chk(1'b1, 8'h02, 1'b0, "mid_v2");
      send_chk(1'b1, 8'h03, 1'b0, "mid_v3");
      send_chk(1'b1, 8'h04, 1'b1, "mid_v4");
      chk("mid_word", 64'(tx_bytes32), 64'h01020304);
      send_chk(1'b0, 8'h00, 1'b0, "mid_after");

      // Byte coincident with reset is dropped.
      rst = 1'b1;
      send_chk(1'b1, 8'hEE, 1'b0, "drop_rst");
      chk("drop_bytes", 64'(tx_bytes32), 64'h0);
      rst = 1'b0;
      send_chk(1'b1, 8'h10, 1'b0, "drop_v1");
      send_chk(1'b1, 8'h20, 1'b0, "drop_v2");
      send_chk(1'b1, 8'h30, 1'b0, "drop_v3");
      send_chk(1'b1, 8'h40, 1'b1, "drop_v4");
      chk("drop_word", 64'(tx_bytes32), 64'h10203040);

      // Width sweep: 16-bit and 64-bit instances fed the same byte run.
      do_reset();
      seq_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      for (int i = 0; i < 8; i++) begin
         send(1'b1, seq_b[i]);
         chk($sformatf("n16_v%0d", i), 64'(tx_valid16), 64'(i % 2 == 1));
         chk($sformatf("n64_v%0d", i), 64'(tx_valid64), 64'(i == 7));
      end
      chk("n16_word", 64'(tx_bytes16), 64'h0708);
      chk("n64_word", tx_bytes64, 64'h0102030405060708);
      send(1'b0, 8'h00);
      chk("n16_after", 64'(tx_valid16), 64'h0);
      chk("n64_after", 64'(tx_valid64), 64'h0);

      do_reset();
      send(1'b1, 8'hA1);
      send(1'b1, 8'hB2);
      chk("n16_pair_v", 64'(tx_valid16), 64'h1);
      chk("n16_pair", 64'(tx_bytes16), 64'hA1B2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 Parameter N, default 32: output word width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter Ndiv4log2, default 3: byte-counter width, equal to log2(N/4); SHALL hold values 0..N/8-1.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port rx_valid, input, 1: rx_byte carries a valid byte this cycle.
REQ-006 Port rx_byte, input, 8: incoming serial byte.
REQ-007 Port tx_bytes, output, N: assembled parallel word, first-received byte in the MSBs.
REQ-008 Port tx_valid, output, 1: one-cycle pulse marking tx_bytes as a complete word.

Function
REQ-009 The block SHALL accept one byte on each rising clk edge where rx_valid=1 and rst=0.
- No ready/backpressure.
- Every valid byte is consumed.
REQ-010 Each accepted byte SHALL shift in at the LSB end: tx_bytes <= {tx_bytes[N-9:0], rx_byte}.
REQ-011 A byte counter (Ndiv4log2 bits) SHALL behave as follows.
- Increments on each accepted byte.
- Wraps to 0 when the accepted byte is byte N/8 of a word (count was N/8-1).
REQ-012 tx_valid SHALL be registered and assert for exactly the one cycle after the edge that accepts the word's last byte.
- Latency: 1 cycle from the last byte at the input.
REQ-013 tx_valid SHALL be 0 in every other cycle, including when rx_valid=0.
REQ-014 When rx_valid=0, counter and tx_bytes SHALL hold.
- Idle gaps of any length between bytes SHALL NOT disturb assembly.
REQ-015 Back-to-back words SHALL be supported: rx_valid may be 1 in the tx_valid cycle.
- That byte becomes byte 1 of the next word.
- tx_bytes starts shifting on that edge, so consumers SHALL sample tx_bytes while tx_valid=1.
REQ-016 tx_bytes outside the tx_valid cycle is a partial or stale word and carries no meaning.

Reset
REQ-017 While rst=1 at a clk edge, the block SHALL set:
- tx_bytes = 0
- counter = 0
- tx_valid = 0
REQ-018 rst SHALL take priority over a simultaneous rx_valid; that byte is dropped.
REQ-019 Reset mid-word SHALL discard the partial word; the next accepted byte is byte 1.
REQ-020 After rst deasserts, the first accepted byte SHALL be treated as byte 1 of a new word.

Structure
REQ-021 Single module, no sub-modules and no shared package.
- N and Ndiv4log2 are module parameters.
- The terminal count N/8-1 SHALL be a localparam.
REQ-022 Three registers only: the N-bit shift register (driving tx_bytes), the counter and the tx_valid flop.
- No combinational path from inputs to outputs.

Verification
REQ-023 Reset then AA, BB, CC, DD on consecutive cycles with rx_valid=1 -> the next cycle shows tx_bytes=AABBCCDD and tx_valid=1; the cycle after, tx_valid=0.
REQ-024 The four bytes of REQ-023 with idle cycles (rx_valid=0) between them -> tx_valid stays 0 until 1 cycle after DD; tx_bytes=AABBCCDD.
REQ-025 Words 11223344 then 55667788 streamed back-to-back (8 consecutive valid cycles) -> tx_valid pulses twice, 4 cycles apart, carrying 11223344 then 55667788.
REQ-026 Bytes AA, BB accepted, rst pulsed, then 01, 02, 03, 04 -> tx_valid once, tx_bytes=01020304; tx_valid=0 during and right after reset.
REQ-027 rst=1 and rx_valid=1 with byte EE on the same edge, then 4 bytes 10, 20, 30, 40 -> word is 10203040 (EE dropped).
REQ-028 Parameter sweep N=16 and N=64 (Ndiv4log2=2 and 4) -> tx_valid after every 2 and 8 bytes respectively, MSB-first ordering preserved.
